dot_seq_ctrl: RTL and testbench
===============================

# dot_seq_ctrl

Sequencer for one 8x8-bit signed multiply-accumulate unit with a 24-bit accumulator. Given a job (tap count, two buffer base addresses, bias), it streams activation/weight pairs from two synchronous-read buffers into the MAC. It seeds the accumulator with the bias, drains the MAC pipeline and applies optional ReLU. It presents the 24-bit result through a valid/ready handshake. It sits between the layer scheduler (issues jobs) and a shared MAC instance (clock-enable, operand and feedback driven by this block).

## Interface
- ADDR_W, 8: buffer address width; max taps per job = 2^ADDR_W
- ACC_W, 24: accumulator/result width
- clk  in  1  clock
- sclr  in  1  reset, asynchronous, active-high
- start  in  1  job request, sampled only in IDLE
- len  in  ADDR_W+1  tap count, 0..2^ADDR_W
- base_a, base_b  in  ADDR_W  activation / weight buffer base addresses
- bias  in  ACC_W  signed accumulator seed
- relu_en  in  1  clamp negative result to 0
- rd_en  out  1  buffer read strobe; data returns next cycle
- addr_a, addr_b  out  ADDR_W  buffer read addresses
- act_in, wgt_in  in  8  signed buffer read data (valid cycle after rd_en)
- mac_ce  out  1  MAC clock enable
- mac_a, mac_b  out  8  MAC operands
- mac_c  out  ACC_W  MAC addend
- mac_p  in  ACC_W  MAC registered output (p <= a*b+c on ce)
- result  out  ACC_W  final signed sum
- result_valid  out  1  result held valid
- out_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, LAST, CAPT, OUT.
- IDLE:
  - start=1 latches len, base_a, base_b, bias and relu_en; clears tap counter i.
  - len>0 -> RUN; len=0 -> CAPT with zero_len flag set.
- RUN (len cycles): rd_en=1, addr_a=base_a+i, addr_b=base_b+i, modulo 2^ADDR_W (wraps); i increments. Exits after i=len-1 issued -> LAST.
- MAC feed, registered copy of rd_en, so in RUN cycles 2..len and in LAST:
  - mac_ce=1, mac_a=act_in, mac_b=wgt_in.
  - mac_c = latched bias for tap 0; mac_c = mac_p (combinational feedback) for every later tap.
- LAST: rd_en=0; final tap MAC'd -> CAPT.
- CAPT: mac_ce=0; result <= zero_len ? bias : mac_p; if relu_en and value negative, result <= 0 -> OUT.
- OUT: result_valid=1, result stable; transfer when out_ready=1 -> IDLE.
- Outside the feed cycles, mac_ce=0 and mac_a/mac_b/mac_c=0.
- Arithmetic: 16-bit signed product plus ACC_W sum, two's-complement wrap in the MAC. No overflow detection or saturation.
- start outside IDLE is ignored, including during OUT. The earliest next start is sampled in the cycle after the handshake cycle.
- Inputs other than act_in/wgt_in/mac_p/out_ready are don't-care after latch.

## Timing
- Reset (async assert): state IDLE; rd_en, addr_a, addr_b, mac_ce, mac_a, mac_b, mac_c, result, result_valid, busy all 0. The MAC shares sclr, so a reset mid-job aborts with no result_valid and no further reads.
- start sampled at edge E0:
  - rd_en is high in the cycles after E0..E(len-1).
  - mac_ce is high in the cycles after E1..E(len).
  - result_valid rises after edge E(len+2).
  - len=0: result_valid rises after E2.
- Job throughput: len+3 cycles plus the handshake wait.
- busy rises the cycle after E0 and falls the cycle after the handshake.
- out_ready low holds OUT indefinitely with result unchanged. No read or MAC activity occurs during the wait.

## Test plan
- len=3, act=[1,2,3], wgt=[4,5,6], bias=10, relu_en=0, out_ready=1:
  - result=42 (0x00002A), valid 5 cycles after the start edge, for one cycle.
  - mac_ce high for exactly 3 cycles.
- len=1, act=-5, wgt=3, bias=2: relu_en=0 -> result=0xFFFFF3 (-13); relu_en=1 -> result=0.
- len=0, bias=-7 (0xFFFFF9):
  - no rd_en, no mac_ce.
  - result=0xFFFFF9, valid 2 cycles after the start edge.
- ADDR_W=8, base_a=254, base_b=10, len=4 -> addr_a sequence 254,255,0,1; addr_b sequence 10,11,12,13.
- Back-pressure: out_ready=0 for 5 cycles after result_valid, with start pulsed during the wait:
  - result and result_valid are held; the start is ignored.
  - after out_ready=1, busy=0 the next cycle, and a new start is accepted.
- sclr pulse mid-RUN of a len=8 job:
  - all outputs 0 immediately; no result_valid.
  - a subsequent len=2 job (act=[2,2], wgt=[3,3], bias=0) gives 12.

Source files
------------

// File: rtl/dot_seq_ctrl.sv
// Purpose: sequences one signed 8x8 MAC job; streams operand pairs from two buffers, seeds the
//          accumulator with a bias, drains the MAC pipeline, applies optional ReLU.
// Latency: result_valid rises after edge E(len+2) from the start edge E0 (after E2 for len=0).
// Backpressure: result is held in OUT until out_ready; no reads or MAC activity while waiting.
//
// Ports:
//   clk, sclr                      clock, asynchronous active-high reset (shared with the MAC)
//   start, len, base_a, base_b,    job request and parameters, latched in IDLE
//   bias, relu_en
//   rd_en, addr_a, addr_b          buffer read port (read data returns the following cycle)
//   act_in, wgt_in                 signed buffer read data
//   mac_ce, mac_a, mac_b, mac_c    MAC control/operands (p <= a*b + c on ce)
//   mac_p                          MAC registered output
//   result, result_valid,          final sum with valid/ready handshake
//   out_ready
//   busy                           job in progress
module dot_seq_ctrl #(
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     sclr,
    input  logic                     start,
    input  logic [ADDR_W:0]          len,
    input  logic [ADDR_W-1:0]        base_a,
    input  logic [ADDR_W-1:0]        base_b,
    input  logic [ACC_W-1:0]         bias,
    input  logic                     relu_en,
    output logic                     rd_en,
    output logic [ADDR_W-1:0]        addr_a,
    output logic [ADDR_W-1:0]        addr_b,
    input  logic [7:0]               act_in,
    input  logic [7:0]               wgt_in,
    output logic                     mac_ce,
    output logic [7:0]               mac_a,
    output logic [7:0]               mac_b,
    output logic [ACC_W-1:0]         mac_c,
    input  logic [ACC_W-1:0]         mac_p,
    output logic [ACC_W-1:0]         result,
    output logic                     result_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        LAST = 3'd2,
        CAPT = 3'd3,
        OUT  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state;
    logic [ADDR_W:0]     len_r;
    logic [ADDR_W:0]     i;          // index of the next tap to issue
    logic [ADDR_W-1:0]   base_a_r;
    logic [ADDR_W-1:0]   base_b_r;
    logic [ACC_W-1:0]    bias_r;
    logic                relu_r;
    logic                zero_len;
    logic                cap_dly;    // extra CAPT cycle for empty jobs, keeps len=0 timing at E2
    logic                feed;       // rd_en delayed one cycle: buffer data is at the MAC inputs
    logic                tap0_pend;  // next fed tap is tap 0, so its addend is the bias

    logic [ACC_W-1:0]    capt_val;

    // MAC drive: operands come straight from the buffer read data during feed cycles.
    // Later taps chain through the MAC's own registered output.
    assign mac_ce = feed;
    assign mac_a  = feed ? act_in : 8'd0;
    assign mac_b  = feed ? wgt_in : 8'd0;
    assign mac_c  = !feed ? '0 : (tap0_pend ? bias_r : mac_p);

    assign capt_val = zero_len ? bias_r : mac_p;

    always_ff @(posedge clk or posedge sclr) begin
        if (sclr) begin
            state        <= IDLE;
            len_r        <= '0;
            i            <= '0;
            base_a_r     <= '0;
            base_b_r     <= '0;
            bias_r       <= '0;
            relu_r       <= 1'b0;
            zero_len     <= 1'b0;
            cap_dly      <= 1'b0;
            feed         <= 1'b0;
            tap0_pend    <= 1'b0;
            rd_en        <= 1'b0;
            addr_a       <= '0;
            addr_b       <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            feed <= rd_en;
            if (feed) begin
                tap0_pend <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        len_r    <= len;
                        base_a_r <= base_a;
                        base_b_r <= base_b;
                        bias_r   <= bias;
                        relu_r   <= relu_en;
                        cap_dly  <= 1'b0;
                        busy     <= 1'b1;
                        if (len == '0) begin
                            zero_len <= 1'b1;
                            i        <= '0;
                            state    <= CAPT;
                        end else begin
                            // Tap 0 is issued straight from the start inputs.
                            zero_len  <= 1'b0;
                            tap0_pend <= 1'b1;
                            rd_en     <= 1'b1;
                            addr_a    <= base_a;
                            addr_b    <= base_b;
                            i         <= ONE;
                            state     <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (i == len_r) begin
                        rd_en <= 1'b0;
                        state <= LAST;
                    end else begin
                        // Address sums wrap modulo 2^ADDR_W by truncation.
                        addr_a <= base_a_r + i[ADDR_W-1:0];
                        addr_b <= base_b_r + i[ADDR_W-1:0];
                        i      <= i + ONE;
                    end
                end

                LAST: begin
                    state <= CAPT;
                end

                CAPT: begin
                    if (zero_len && !cap_dly) begin
                        cap_dly <= 1'b1;
                    end else begin
                        if (relu_r && capt_val[ACC_W-1]) begin
                            result <= '0;
                        end else begin
                            result <= capt_val;
                        end
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end

                OUT: begin
                    if (out_ready) begin
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_seq_ctrl.sv
module tb_dot_seq_ctrl;

    localparam int ADDR_W = 8;
    localparam int ACC_W  = 24;

    logic                clk;
    logic                sclr;
    logic                start;
    logic [ADDR_W:0]     len;
    logic [ADDR_W-1:0]   base_a;
    logic [ADDR_W-1:0]   base_b;
    logic [ACC_W-1:0]    bias;
    logic                relu_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   addr_a;
    logic [ADDR_W-1:0]   addr_b;
    logic [7:0]          act_in;
    logic [7:0]          wgt_in;
    logic                mac_ce;
    logic [7:0]          mac_a;
    logic [7:0]          mac_b;
    logic [ACC_W-1:0]    mac_c;
    logic [ACC_W-1:0]    mac_p;
    logic [ACC_W-1:0]    result;
    logic                result_valid;
    logic                out_ready;
    logic                busy;

    int n_cmp  = 0;
    int n_fail = 0;

    dot_seq_ctrl #(.ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk          (clk),
        .sclr         (sclr),
        .start        (start),
        .len          (len),
        .base_a       (base_a),
        .base_b       (base_b),
        .bias         (bias),
        .relu_en      (relu_en),
        .rd_en        (rd_en),
        .addr_a       (addr_a),
        .addr_b       (addr_b),
        .act_in       (act_in),
        .wgt_in       (wgt_in),
        .mac_ce       (mac_ce),
        .mac_a        (mac_a),
        .mac_b        (mac_b),
        .mac_c        (mac_c),
        .mac_p        (mac_p),
        .result       (result),
        .result_valid (result_valid),
        .out_ready    (out_ready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer models: synchronous read, data valid the cycle after rd_en.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk) begin
        if (rd_en) begin
            act_in <= mem_a[addr_a];
            wgt_in <= mem_b[addr_b];
        end
    end

    // MAC model: p <= a*b + c on ce, signed, wrapping at ACC_W bits; shares sclr.
    wire signed [15:0] prod = $signed(mac_a) * $signed(mac_b);
    always @(posedge clk or posedge sclr) begin
        if (sclr) begin
            mac_p <= '0;
        end else if (mac_ce) begin
            mac_p <= mac_c + {{(ACC_W-16){prod[15]}}, prod};
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [ADDR_W:0]   len;
        logic [ADDR_W-1:0] ba;
        logic [ADDR_W-1:0] bb;
        logic [ACC_W-1:0]  bias;
        logic              relu;
        logic [ACC_W-1:0]  exp_res;
        int                exp_lat;
        int                exp_rd;
        int                exp_ce;
    } vec_t;

    vec_t vt [8];

    // Issues one job with out_ready held high and checks the whole transaction.
    task automatic run_job(input vec_t v, input string tag);
        int k, rd_cnt, ce_cnt, vld_cnt, first;
        logic [ACC_W-1:0] got;
        logic [ADDR_W-1:0] ea, eb;
        bit done;
        rd_cnt = 0; ce_cnt = 0; vld_cnt = 0; first = -1; got = '0; done = 0; k = 0;
        len = v.len; base_a = v.ba; base_b = v.bb; bias = v.bias; relu_en = v.relu;
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble latched-only inputs to show they are not re-read.
        len = '1; base_a = 8'h5A; base_b = 8'hA5; bias = 24'h123456; relu_en = ~v.relu;
        chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        while (!done && k < 400) begin
            if (rd_en) begin
                ea = v.ba + rd_cnt[ADDR_W-1:0];
                eb = v.bb + rd_cnt[ADDR_W-1:0];
                chk({tag, " addr_a"}, {24'd0, addr_a}, {24'd0, ea});
                chk({tag, " addr_b"}, {24'd0, addr_b}, {24'd0, eb});
                rd_cnt++;
            end
            if (mac_ce) ce_cnt++;
            if (result_valid) begin
                if (vld_cnt == 0) begin
                    first = k;
                    got   = result;
                end
                vld_cnt++;
            end
            if (vld_cnt > 0 && !result_valid) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                k++;
            end
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: no completed handshake within 400 cycles", tag);
        end
        chk({tag, " result"},      {8'd0, got},       {8'd0, v.exp_res});
        chk({tag, " latency"},     first,             v.exp_lat);
        chk({tag, " rd_cycles"},   rd_cnt,            v.exp_rd);
        chk({tag, " ce_cycles"},   ce_cnt,            v.exp_ce);
        chk({tag, " valid_cycles"}, vld_cnt,          32'd1);
        chk({tag, " busy_after"},  {31'd0, busy},     32'd0);
    endtask

    initial begin
        int w;
        for (int j = 0; j < 256; j++) begin
            mem_a[j] = 8'd0;
            mem_b[j] = 8'd0;
        end
        // len=3 dot product
        mem_a[0] = 8'd1;  mem_a[1] = 8'd2;  mem_a[2] = 8'd3;
        mem_b[0] = 8'd4;  mem_b[1] = 8'd5;  mem_b[2] = 8'd6;
        // single negative tap
        mem_a[3] = 8'hFB; mem_b[3] = 8'd3;
        // wrapping address window
        mem_a[254] = 8'd3; mem_a[255] = 8'hFF;
        mem_b[10] = 8'd1; mem_b[11] = 8'd2; mem_b[12] = 8'd3; mem_b[13] = 8'd4;
        // accumulator wrap
        mem_a[20] = 8'h7F; mem_b[20] = 8'h7F;
        // most negative operands
        mem_a[30] = 8'h80; mem_a[31] = 8'h80; mem_b[30] = 8'h80; mem_b[31] = 8'h80;
        // post-reset job
        mem_a[40] = 8'd2; mem_a[41] = 8'd2; mem_b[40] = 8'd3; mem_b[41] = 8'd3;

        //        len    ba       bb      bias          relu  expected      lat rd ce
        vt[0] = '{9'd3, 8'd0,   8'd0,  24'd10,       1'b0, 24'h00002A,  5, 3, 3};
        vt[1] = '{9'd1, 8'd3,   8'd3,  24'd2,        1'b0, 24'hFFFFF3,  3, 1, 1};
        vt[2] = '{9'd1, 8'd3,   8'd3,  24'd2,        1'b1, 24'h000000,  3, 1, 1};
        vt[3] = '{9'd0, 8'd7,   8'd9,  24'hFFFFF9,   1'b0, 24'hFFFFF9,  2, 0, 0};
        vt[4] = '{9'd4, 8'd254, 8'd10, 24'd0,        1'b0, 24'h00000C,  6, 4, 4};
        vt[5] = '{9'd1, 8'd20,  8'd20, 24'h7FFFFF,   1'b0, 24'h803F00,  3, 1, 1};
        vt[6] = '{9'd2, 8'd30,  8'd30, 24'hFFFFFF,   1'b1, 24'h007FFF,  4, 2, 2};
        vt[7] = '{9'd2, 8'd40,  8'd40, 24'd0,        1'b0, 24'h00000C,  4, 2, 2};

        sclr = 1'b1; start = 1'b0; len = '0; base_a = '0; base_b = '0; bias = '0;
        relu_en = 1'b0; out_ready = 1'b1;
        #1;
        chk("reset rd_en",        {31'd0, rd_en},        32'd0);
        chk("reset addr",         {16'd0, addr_a, addr_b}, 32'd0);
        chk("reset mac_ce",       {31'd0, mac_ce},       32'd0);
        chk("reset mac_ops",      {16'd0, mac_a, mac_b}, 32'd0);
        chk("reset mac_c",        {8'd0, mac_c},         32'd0);
        chk("reset result",       {8'd0, result},        32'd0);
        chk("reset result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset busy",         {31'd0, busy},         32'd0);
        @(posedge clk); @(posedge clk); #1;
        sclr = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 7; n++) begin
            run_job(vt[n], $sformatf("vec%0d", n));
        end

        // Back-pressure: hold out_ready low, pulse start during the wait.
        len = vt[0].len; base_a = vt[0].ba; base_b = vt[0].bb; bias = vt[0].bias;
        relu_en = 1'b0; out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while (!result_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("bp valid_seen", {31'd0, result_valid}, 32'd1);
        chk("bp result",     {8'd0, result},        32'h2A);
        for (int j = 0; j < 5; j++) begin
            start = (j == 2);
            len = 9'd1; base_a = 8'd3; base_b = 8'd3;
            @(posedge clk); #1;
            chk("bp hold_valid",  {31'd0, result_valid}, 32'd1);
            chk("bp hold_result", {8'd0, result},        32'h2A);
            chk("bp no_rd",       {31'd0, rd_en},        32'd0);
            chk("bp no_mac",      {31'd0, mac_ce},       32'd0);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp busy_released", {31'd0, busy},         32'd0);
        chk("bp valid_dropped", {31'd0, result_valid}, 32'd0);
        run_job(vt[1], "bp_next");

        // Reset pulse in the middle of a len=8 job.
        len = 9'd8; base_a = 8'd0; base_b = 8'd0; bias = 24'd5; relu_en = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        chk("abort running", {31'd0, rd_en & busy}, 32'd1);
        sclr = 1'b1;
        #1;
        chk("abort rd_en",   {31'd0, rd_en},          32'd0);
        chk("abort addr",    {16'd0, addr_a, addr_b}, 32'd0);
        chk("abort mac",     {7'd0, mac_ce, mac_a, mac_b, 8'd0}, 32'd0);
        chk("abort mac_c",   {8'd0, mac_c},           32'd0);
        chk("abort result",  {8'd0, result},          32'd0);
        chk("abort valid",   {30'd0, result_valid, busy}, 32'd0);
        @(posedge clk); #1;
        sclr = 1'b0;
        for (int j = 0; j < 12; j++) begin
            @(posedge clk); #1;
            if (result_valid || rd_en || busy) begin
                n_fail++;
                $display("FAIL abort quiet: activity after reset, valid=%0d rd_en=%0d busy=%0d, expected 0",
                         result_valid, rd_en, busy);
            end
        end
        n_cmp++;
        run_job(vt[7], "post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
